exec_stage_q: RTL
=================

// Module: exec_stage_q
// PURPOSE
//  Parametrised execute stage between operand-fetch/memory and writeback. Accepts one decoded
//  instruction per handshake, computes it (single-cycle ALU ops or iterative multiply), and
//  queues results in an OUT_DEPTH-entry FIFO drained by writeback via valid/ready.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width (>=8)
//  ADDR_WIDTH  16  pc and destination-address width
//  OUT_DEPTH   4   result FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           asynchronous, active-low reset
//  i_input_valid  in   1           upstream instruction valid
//  o_ready        out  1           stage can accept (handshake = i_input_valid & o_ready)
//  i_pc           in   ADDR_WIDTH  instruction pc
//  i_opcode       in   8           opcode (`OPC_* from header.v)
//  i_opA/i_opB    in   DATA_WIDTH  operands
//  i_dest_reg     in   4           destination register
//  i_dest_addr    in   ADDR_WIDTH  destination memory address
//  i_next_ready   in   1           writeback can take head entry
//  o_res_valid    out  1           FIFO non-empty; head entry on outputs below
//  o_pc,o_opcode,o_res,o_dest_reg,o_dest_addr  out  (as inputs)  head entry fields
//  o_illegal      out  1           head entry had unimplemented opcode
//  o_busy         out  1           state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, FIFO empty; o_ready=1 once reset deasserts, all other
//   outputs 0. Reset mid-op aborts the instruction/multiply and discards FIFO contents.
//  FSM: IDLE -> EXEC on accept (operands, pc, opcode, dest latched).
//   EXEC: single-cycle op -> push, return IDLE; `OPC_MUL -> MUL (cnt=0).
//   MUL: shift-add, one opB bit/cycle; after DATA_WIDTH cycles -> push, IDLE.
//   Push blocked (FIFO full, no pop this cycle): hold in EXEC/MUL-done (WAIT), result frozen.
//  o_ready = (state==IDLE); max throughput 1 instr / 2 cycles.
//  Latency: accept at edge N -> o_res_valid high after edge N+1 (single-cycle ops);
//   after edge N+1+DATA_WIDTH (MUL), if FIFO has space.
//  Ops: XOR, AND, OR; ADD/SUB modulo 2^DATA_WIDTH; SHL/SHR logical by
//   opB[$clog2(DATA_WIDTH)-1:0]; MUL low DATA_WIDTH bits of product.
//   Unimplemented opcode: o_res=0, o_illegal=1; entry still pushed (writeback discards it).
//  FIFO: pop = o_res_valid & i_next_ready. Push allowed if count<OUT_DEPTH or pop same cycle;
//   simultaneous push+pop keeps count. Pointers wrap modulo OUT_DEPTH. Outputs show head
//   entry combinationally from storage, stable while not popped.
//  Pop while empty ignored; i_input_valid ignored when o_ready=0 (upstream must hold).
// CONFIGURATION
//  EXEC_FLAGS_EN defined: extra port o_flags out 4 = {N,Z,C,V} per entry, stored in FIFO.
//   Z=res==0; N=res MSB; C=carry-out (ADD), borrow (SUB), last bit shifted out (SHL/SHR), else 0;
//   V=signed overflow (ADD/SUB), else 0. Flags 0 on illegal entries.
//  Undefined: no o_flags port, no flag storage; all other behaviour identical.
// TESTING
//  1 Reset: assert reset=0 mid-MUL with 2 entries queued -> o_res_valid=0, o_busy=0, o_ready=1.
//  2 XOR opA=32'hFFFF0000 opB=32'h0F0F0F0F, i_next_ready=1 -> o_res=32'hF0F00F0F,
//    o_res_valid one cycle after accept edge, pc/dest fields match.
//  3 ADD 32'hFFFFFFFF+1 -> o_res=0 (flags build: Z=1,C=1,V=0); SUB 0-1 -> 32'hFFFFFFFF
//    (N=1,C=1).
//  4 MUL 32'd1234*32'd5678 -> o_res=32'd7006652, o_ready low for 33 cycles after accept.
//  5 i_next_ready=0, issue 5 ADDs -> 4 queued, 5th held (o_ready=0); raise i_next_ready ->
//    5 results in issue order, including simultaneous push+pop at full.
//  6 Opcode 8'hEE -> entry with o_res=0, o_illegal=1; following XOR completes normally.

Source files
------------

// File: rtl/exec_stage_q.sv
// exec_stage_q: execute stage (single-cycle ALU ops, iterative shift-add multiply) feeding a result FIFO
// Ports:
//   clk, reset (async, active-low)
//   i_input_valid/o_ready     : instruction handshake (accepted only in IDLE)
//   i_pc, i_opcode, i_opA, i_opB, i_dest_reg, i_dest_addr : decoded instruction
//   i_next_ready              : writeback pops the head entry when o_res_valid is high
//   o_res_valid + o_pc, o_opcode, o_res, o_dest_reg, o_dest_addr, o_illegal : FIFO head entry
//   o_busy                    : instruction in flight or results queued
// Build option EXEC_FLAGS_EN adds o_flags = {N,Z,C,V}, stored per FIFO entry.
module exec_stage_q #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_input_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [7:0]            i_opcode,
    input  logic [DATA_WIDTH-1:0] i_opA,
    input  logic [DATA_WIDTH-1:0] i_opB,
    input  logic [3:0]            i_dest_reg,
    input  logic [ADDR_WIDTH-1:0] i_dest_addr,
    input  logic                  i_next_ready,
    output logic                  o_res_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [7:0]            o_opcode,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic [3:0]            o_dest_reg,
    output logic [ADDR_WIDTH-1:0] o_dest_addr,
    output logic                  o_illegal,
`ifdef EXEC_FLAGS_EN
    output logic [3:0]            o_flags,
`endif
    output logic                  o_busy
);
    localparam logic [7:0] OPC_XOR = 8'h01;
    localparam logic [7:0] OPC_AND = 8'h02;
    localparam logic [7:0] OPC_OR  = 8'h03;
    localparam logic [7:0] OPC_ADD = 8'h04;
    localparam logic [7:0] OPC_SUB = 8'h05;
    localparam logic [7:0] OPC_SHL = 8'h06;
    localparam logic [7:0] OPC_SHR = 8'h07;
    localparam logic [7:0] OPC_MUL = 8'h08;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int M  = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WAIT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [7:0]            opcode;
        logic [DATA_WIDTH-1:0] res;
        logic [3:0]            dest_reg;
        logic [ADDR_WIDTH-1:0] dest_addr;
        logic                  illegal;
`ifdef EXEC_FLAGS_EN
        logic [3:0]            flags;
`endif
    } entry_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc_r, dest_addr_r;
    logic [7:0]            opc_r;
    logic [DATA_WIDTH-1:0] a_r, b_r, acc, mul_next, alu_res;
    logic [3:0]            dest_reg_r;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         sh;
    logic                  alu_ill, last, push, pop, push_ok;
    entry_t                mem [OUT_DEPTH];
    entry_t                in_e, head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    assign sh       = b_r[SW-1:0];
    assign mul_next = acc + (b_r[0] ? a_r : '0);
    assign last     = cnt == CW'(DATA_WIDTH - 1);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (opc_r)
            OPC_XOR: alu_res = a_r ^ b_r;
            OPC_AND: alu_res = a_r & b_r;
            OPC_OR:  alu_res = a_r | b_r;
            OPC_ADD: alu_res = a_r + b_r;
            OPC_SUB: alu_res = a_r - b_r;
            OPC_SHL: alu_res = a_r << sh;
            OPC_SHR: alu_res = a_r >> sh;
            default: alu_ill = 1'b1;
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle
    assign o_res_valid = count != '0;
    assign pop         = o_res_valid & i_next_ready;
    assign push_ok     = (count != (PW + 1)'(OUT_DEPTH)) | pop;
    assign push        = push_ok & ((state == EXEC && opc_r != OPC_MUL) || (state == MUL && last) || state == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_input_valid ? EXEC : IDLE;
            EXEC:    state_n = (opc_r == OPC_MUL) ? MUL : push_ok ? IDLE : EXEC;
            MUL:     state_n = !last ? MUL : push_ok ? IDLE : WAIT;
            WAIT:    state_n = push_ok ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // Multiply consumes one opB bit per cycle: opA shifts left, opB shifts right
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= '0;
            opc_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            dest_reg_r  <= '0;
            dest_addr_r <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            if (state == IDLE && i_input_valid) begin
                pc_r        <= i_pc;
                opc_r       <= i_opcode;
                a_r         <= i_opA;
                b_r         <= i_opB;
                dest_reg_r  <= i_dest_reg;
                dest_addr_r <= i_dest_addr;
            end
            if (state == EXEC) begin
                acc <= '0;
                cnt <= '0;
            end
            if (state == MUL) begin
                acc <= mul_next;
                a_r <= a_r << 1;
                b_r <= b_r >> 1;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        in_e           = '0;
        in_e.pc        = pc_r;
        in_e.opcode    = opc_r;
        in_e.dest_reg  = dest_reg_r;
        in_e.dest_addr = dest_addr_r;
        in_e.illegal   = state == EXEC && alu_ill;
        in_e.res       = in_e.illegal ? '0 : (state == EXEC) ? alu_res : (state == MUL) ? mul_next : acc;
`ifdef EXEC_FLAGS_EN
        // Carry/borrow from operand and result MSBs; shifts report the last bit shifted out
        in_e.flags[3]  = in_e.res[M];
        in_e.flags[2]  = !in_e.illegal && in_e.res == '0;
        in_e.flags[1]  = state != EXEC ? 1'b0
                       : (opc_r == OPC_ADD) ? (a_r[M] & b_r[M]) | ((a_r[M] | b_r[M]) & ~alu_res[M])
                       : (opc_r == OPC_SUB) ? (~a_r[M] & b_r[M]) | ((~a_r[M] | b_r[M]) & alu_res[M])
                       : (opc_r == OPC_SHL) ? (sh != '0) & a_r[SW'(DATA_WIDTH - int'(sh))]
                       : (opc_r == OPC_SHR) ? (sh != '0) & a_r[sh - 1'b1]
                       : 1'b0;
        in_e.flags[0]  = state != EXEC ? 1'b0
                       : (opc_r == OPC_ADD) ? (a_r[M] == b_r[M]) & (alu_res[M] != a_r[M])
                       : (opc_r == OPC_SUB) ? (a_r[M] != b_r[M]) & (alu_res[M] != a_r[M])
                       : 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_e;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Head fields read as zero while the FIFO is empty
    assign head        = o_res_valid ? mem[rd_ptr] : '0;
    assign o_pc        = head.pc;
    assign o_opcode    = head.opcode;
    assign o_res       = head.res;
    assign o_dest_reg  = head.dest_reg;
    assign o_dest_addr = head.dest_addr;
    assign o_illegal   = head.illegal;
`ifdef EXEC_FLAGS_EN
    assign o_flags     = head.flags;
`endif
    assign o_ready     = state == IDLE;
    assign o_busy      = state != IDLE || o_res_valid;
endmodule
